// File: rtl/cdc_pkg.sv
// Shared types and helpers for the dual-clock stream FIFO: gray conversion,
// read-port mode constants and the read-side FSM state encoding.
package cdc_pkg;

    localparam int MODE_AUTO = 0;
    localparam int MODE_VR   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/cdc_stream_fifo_if.sv
// Write/read stream bundle of cdc_stream_fifo. The ovf_cnt signal exists only
// when CDC_STREAM_FIFO_OVF_CNT_EN is defined.
interface cdc_stream_fifo_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          wr_en;
    logic [DW-1:0] wr_dat;
    logic          wr_full;
    logic [AW:0]   wr_level;
    logic          wr_ovf;
    logic          rd_rdy;
    logic [DW-1:0] rd_dat;
    logic          rd_vd;
    logic          rd_empty;
    logic [AW:0]   rd_level;

`ifdef CDC_STREAM_FIFO_OVF_CNT_EN
    logic [15:0]   ovf_cnt;

    modport master (
        output wr_en, wr_dat, rd_rdy,
        input  wr_full, wr_level, wr_ovf, rd_dat, rd_vd, rd_empty, rd_level, ovf_cnt
    );
    modport slave (
        input  wr_en, wr_dat, rd_rdy,
        output wr_full, wr_level, wr_ovf, rd_dat, rd_vd, rd_empty, rd_level, ovf_cnt
    );
`else
    modport master (
        output wr_en, wr_dat, rd_rdy,
        input  wr_full, wr_level, wr_ovf, rd_dat, rd_vd, rd_empty, rd_level
    );
    modport slave (
        input  wr_en, wr_dat, rd_rdy,
        output wr_full, wr_level, wr_ovf, rd_dat, rd_vd, rd_empty, rd_level
    );
`endif

endinterface

// File: rtl/cdc_gray_sync.sv
// Multi-flop synchroniser for a gray-coded pointer crossing into clk's domain.
module cdc_gray_sync #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [STAGES];

    // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/cdc_stream_fifo.sv
// Dual-clock stream FIFO with gray pointers, settle-then-drain read FSM and
// overflow reporting. Define CDC_STREAM_FIFO_OVF_CNT_EN to add the ovf_cnt counter.
module cdc_stream_fifo
    import cdc_pkg::*;
#(
    parameter int DW          = 8,
    parameter int AW          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 3,
    parameter int MODE        = MODE_AUTO
) (
    input logic               rd_clk,
    input logic               rst,
    input logic               wr_clk,
    cdc_stream_fifo_if.slave  bus
);

    localparam int PW = AW + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [1:0]    wr_rst_q, rd_rst_q;
    logic          wr_rst, rd_rst;
    logic [DW-1:0] mem [2**AW];

    logic [PW-1:0] wr_bin, wr_gray, wr_bin_nxt, rd_sync;
    logic          wr_full_c, wr_push, wr_ovf_q;

    logic [PW-1:0] rd_bin, rd_gray, rd_bin_nxt, wr_sync;
    logic          rd_empty_c, slot_free, pop, rd_vd_q;
    logic [DW-1:0] rd_dat_q;
    logic [CW-1:0] cnt;
    rd_state_e     state;

    // Reset asserts immediately, releases two edges later in each domain.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) wr_rst_q <= 2'b11;
        else     wr_rst_q <= {wr_rst_q[0], 1'b0};
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) rd_rst_q <= 2'b11;
        else     rd_rst_q <= {rd_rst_q[0], 1'b0};
    end

    assign wr_rst = wr_rst_q[1];
    assign rd_rst = rd_rst_q[1];

    cdc_gray_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_rd2wr (
        .clk (wr_clk),
        .rst (wr_rst),
        .d   (rd_gray),
        .q   (rd_sync)
    );

    cdc_gray_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_wr2rd (
        .clk (rd_clk),
        .rst (rd_rst),
        .d   (wr_gray),
        .q   (wr_sync)
    );

    // ---------------- write side ----------------
    assign wr_full_c  = (wr_gray == {~rd_sync[AW:AW-1], rd_sync[AW-2:0]});
    assign wr_push    = bus.wr_en && !wr_full_c;
    assign wr_bin_nxt = wr_bin + PW'(1);

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wr_bin   <= '0;
            wr_gray  <= '0;
            wr_ovf_q <= 1'b0;
        end else if (bus.wr_en) begin
            if (wr_full_c) begin
                wr_ovf_q <= 1'b1;
            end else begin
                wr_bin  <= wr_bin_nxt;
                wr_gray <= PW'(bin2gray(32'(wr_bin_nxt)));
            end
        end
    end

    // NOTE: storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge wr_clk) begin
        if (wr_push) mem[wr_bin[AW-1:0]] <= bus.wr_dat;
    end

`ifdef CDC_STREAM_FIFO_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst)                                              ovf_cnt_q <= '0;
        else if (bus.wr_en && wr_full_c && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end

    assign bus.ovf_cnt = ovf_cnt_q;
`endif

    assign bus.wr_full  = wr_full_c;
    assign bus.wr_ovf   = wr_ovf_q;
    assign bus.wr_level = wr_bin - PW'(gray2bin(32'(rd_sync)));

    // ---------------- read side ----------------
    assign rd_empty_c = (rd_gray == wr_sync);
    assign rd_bin_nxt = rd_bin + PW'(1);

    // NOTE: defaults first so no path through the block leaves a value held.
    always_comb begin
        slot_free = 1'b1;
        if (MODE == MODE_VR) slot_free = !rd_vd_q || bus.rd_rdy;
        pop = (state == DRAIN) && !rd_empty_c && slot_free;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_bin   <= '0;
            rd_gray  <= '0;
            rd_dat_q <= '0;
            rd_vd_q  <= 1'b0;
        end else begin
            if (pop) begin
                rd_dat_q <= mem[rd_bin[AW-1:0]];
                rd_vd_q  <= 1'b1;
                rd_bin   <= rd_bin_nxt;
                rd_gray  <= PW'(bin2gray(32'(rd_bin_nxt)));
            end else if (slot_free) begin
                rd_vd_q  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state <= ARM;
                    cnt   <= '0;
                end
                ARM: begin
                    if (!rd_empty_c && cnt == CW'(SETTLE - 1)) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= rd_empty_c ? '0 : cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    // Leave only once a held MODE_VR word has been taken.
                    if (rd_empty_c && slot_free) begin
                        state <= ARM;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_dat   = rd_dat_q;
    assign bus.rd_vd    = rd_vd_q;
    assign bus.rd_empty = rd_empty_c;
    assign bus.rd_level = PW'(gray2bin(32'(wr_sync))) - rd_bin;

endmodule

// File: tb/tb_cdc_stream_fifo.sv
// Directed bench for cdc_stream_fifo: one auto-drain and one valid/ready instance
// sharing clocks and reset; ovf_cnt is checked when CDC_STREAM_FIFO_OVF_CNT_EN is set.
`timescale 1ns/1ps
module tb_cdc_stream_fifo;
    import cdc_pkg::*;

    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int SYNC   = 2;
    localparam int SETTLE = 3;

    logic    wr_clk = 1'b0;
    logic    rd_clk = 1'b0;
    logic    rst    = 1'b1;
    bit      rd_run = 1'b1;
    realtime wr_half = 5.0;
    realtime rd_half = 12.5;

    int checks = 0;
    int errors = 0;

    always begin
        #(wr_half);
        wr_clk = ~wr_clk;
    end

    // rd_clk can be parked low to freeze the read domain.
    always begin
        #(rd_half);
        if (rd_run || rd_clk) rd_clk = ~rd_clk;
    end

    cdc_stream_fifo_if #(.DW(DW), .AW(AW)) if0 ();
    cdc_stream_fifo_if #(.DW(DW), .AW(AW)) if1 ();

    cdc_stream_fifo #(.DW(DW), .AW(AW), .SYNC_STAGES(SYNC), .SETTLE(SETTLE), .MODE(MODE_AUTO)) dut0 (
        .rd_clk (rd_clk),
        .rst    (rst),
        .wr_clk (wr_clk),
        .bus    (if0)
    );

    cdc_stream_fifo #(.DW(DW), .AW(AW), .SYNC_STAGES(SYNC), .SETTLE(SETTLE), .MODE(MODE_VR)) dut1 (
        .rd_clk (rd_clk),
        .rst    (rst),
        .wr_clk (wr_clk),
        .bus    (if1)
    );

    // Words leaving each instance, captured away from the active edge.
    logic [DW-1:0] rx0 [$];
    logic [DW-1:0] rx1 [$];

    always @(negedge rd_clk) begin
        if (if0.rd_vd)               rx0.push_back(if0.rd_dat);
        if (if1.rd_vd && if1.rd_rdy) rx1.push_back(if1.rd_dat);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string p, input logic full, input logic [AW:0] wlvl,
                                     input logic ovf, input logic vd, input logic [DW-1:0] dat,
                                     input logic empty, input logic [AW:0] rlvl);
        check({p, "_wr_full"},  32'(full),  32'd0);
        check({p, "_wr_level"}, 32'(wlvl),  32'd0);
        check({p, "_wr_ovf"},   32'(ovf),   32'd0);
        check({p, "_rd_vd"},    32'(vd),    32'd0);
        check({p, "_rd_dat"},   32'(dat),   32'd0);
        check({p, "_rd_empty"}, 32'(empty), 32'd1);
        check({p, "_rd_level"}, 32'(rlvl),  32'd0);
    endtask

    task automatic sync_wr();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic rd_cycles(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    // Drive one write beat on instance inst; returns 1 ns after the capturing edge.
    task automatic wr_word(input int inst, input logic [DW-1:0] d);
        if (inst == 0) begin if0.wr_en = 1'b1; if0.wr_dat = d; end
        else           begin if1.wr_en = 1'b1; if1.wr_dat = d; end
        @(posedge wr_clk);
        #1;
        if0.wr_en = 1'b0;
        if1.wr_en = 1'b0;
    endtask

    task automatic wait_rx(input int inst, input int n, input int budget, input string tag);
        int k = 0;
        while (((inst == 0) ? rx0.size() : rx1.size()) < n && k < budget) begin
            @(posedge rd_clk);
            k++;
        end
        #1;
        check(tag, 32'((inst == 0) ? rx0.size() : rx1.size()), 32'(n));
    endtask

    // rd_clk edges from the write's capturing wr edge until rd_vd is seen high.
    task automatic single_write_latency(input logic [DW-1:0] d, output int n);
        sync_wr();
        if0.wr_en  = 1'b1;
        if0.wr_dat = d;
        @(posedge wr_clk);
        #1;
        if0.wr_en = 1'b0;
        n = 0;
        while (n < 30) begin
            @(posedge rd_clk);
            n++;
            #1;
            if (if0.rd_vd) break;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    logic [DW-1:0] exp0 [$];
    logic [DW-1:0] exp1 [$];

    initial begin
        int b0, b1, lat, drops0, drops1;
        logic en0, en1, wr_done;
        logic [DW-1:0] d0, d1;

        if0.wr_en = 1'b0; if0.wr_dat = '0; if0.rd_rdy = 1'b0;
        if1.wr_en = 1'b0; if1.wr_dat = '0; if1.rd_rdy = 1'b0;
        drops0 = 0;
        drops1 = 0;

        // Reset state
        #43;
        check_reset_state("rst0", if0.wr_full, if0.wr_level, if0.wr_ovf, if0.rd_vd, if0.rd_dat, if0.rd_empty, if0.rd_level);
        check_reset_state("rst1", if1.wr_full, if1.wr_level, if1.wr_ovf, if1.rd_vd, if1.rd_dat, if1.rd_empty, if1.rd_level);
        #57 rst = 1'b0;
        rd_cycles(10);

        // 1: auto-drain of five words in order
        b0 = rx0.size();
        sync_wr();
        for (int i = 1; i <= 5; i++) wr_word(0, DW'(i));
        wait_rx(0, b0 + 5, 200, "t1_count");
        rd_cycles(4);
        check("t1_no_extra", 32'(rx0.size() - b0), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("t1_word%0d", i), 32'(rx0[b0+i]), 32'(i + 1));
        check("t1_empty", 32'(if0.rd_empty), 32'd1);

        // 2: fill with the read domain frozen; 17th word is dropped
        rd_run = 1'b0;
        #30;
        b0 = rx0.size();
        sync_wr();
        for (int i = 0; i < 17; i++) begin
            wr_word(0, DW'(8'h10 + i));
            if (i == 14) begin
                check("t2_full_at15",  32'(if0.wr_full),  32'd0);
                check("t2_level_at15", 32'(if0.wr_level), 32'd15);
            end
            if (i == 15) begin
                check("t2_full_at16",  32'(if0.wr_full),  32'd1);
                check("t2_level_at16", 32'(if0.wr_level), 32'd16);
                check("t2_ovf_at16",   32'(if0.wr_ovf),   32'd0);
            end
        end
        check("t2_ovf_at17",   32'(if0.wr_ovf),   32'd1);
        check("t2_level_at17", 32'(if0.wr_level), 32'd16);
`ifdef CDC_STREAM_FIFO_OVF_CNT_EN
        check("t2_ovf_cnt", 32'(if0.ovf_cnt), 32'd1);
`endif
        rd_run = 1'b1;
        wait_rx(0, b0 + 16, 300, "t2_count");
        rd_cycles(4);
        check("t2_no_extra", 32'(rx0.size() - b0), 32'd16);
        for (int i = 0; i < 16; i++) check($sformatf("t2_word%0d", i), 32'(rx0[b0+i]), 32'(8'h10 + i));
        sync_wr();
        repeat (4) sync_wr();
        check("t2_level_drained", 32'(if0.wr_level), 32'd0);
        check("t2_ovf_sticky",    32'(if0.wr_ovf),   32'd1);

        // 3: valid/ready holds word0 until accepted, then one word per beat
        b1 = rx1.size();
        if1.rd_rdy = 1'b0;
        sync_wr();
        for (int i = 0; i < 4; i++) wr_word(1, DW'(8'h31 + i));
        rd_cycles(20);
        check("t3_vd_held",  32'(if1.rd_vd),    32'd1);
        check("t3_dat_held", 32'(if1.rd_dat),   32'h31);
        check("t3_rd_level", 32'(if1.rd_level), 32'd3);
        rd_cycles(3);
        check("t3_dat_stable", 32'(if1.rd_dat), 32'h31);
        check("t3_none_taken", 32'(rx1.size() - b1), 32'd0);
        for (int k = 0; k < 40 && (rx1.size() - b1) < 4; k++) begin
            if1.rd_rdy = ~if1.rd_rdy;
            @(posedge rd_clk);
            #1;
        end
        if1.rd_rdy = 1'b0;
        check("t3_count", 32'(rx1.size() - b1), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("t3_word%0d", i), 32'(rx1[b1+i]), 32'(8'h31 + i));
        rd_cycles(3);
        check("t3_vd_low", 32'(if1.rd_vd),    32'd0);
        check("t3_empty",  32'(if1.rd_empty), 32'd1);

        // 4: single-word latency from ARM, twice to confirm the return to ARM
        b0 = rx0.size();
        single_write_latency(8'h6C, lat);
        check("t4_lat_min", 32'(lat >= SYNC + SETTLE + 1), 32'd1);
        check("t4_lat_max", 32'(lat <= SYNC + SETTLE + 2), 32'd1);
        check("t4_dat", 32'(if0.rd_dat), 32'h6C);
        rd_cycles(4);
        check("t4_empty", 32'(if0.rd_empty), 32'd1);
        single_write_latency(8'h93, lat);
        check("t4b_lat_min", 32'(lat >= SYNC + SETTLE + 1), 32'd1);
        check("t4b_dat", 32'(if0.rd_dat), 32'h93);
        rd_cycles(4);
        check("t4_words", 32'(rx0.size() - b0), 32'd2);

        // 5: asynchronous reset in the middle of a burst
        sync_wr();
        fork
            for (int i = 0; i < 8; i++) wr_word(0, DW'(8'h50 + i));
            begin
                #37.3 rst = 1'b1;
                #1;
                check_reset_state("t5_0", if0.wr_full, if0.wr_level, if0.wr_ovf, if0.rd_vd, if0.rd_dat, if0.rd_empty, if0.rd_level);
                check_reset_state("t5_1", if1.wr_full, if1.wr_level, if1.wr_ovf, if1.rd_vd, if1.rd_dat, if1.rd_empty, if1.rd_level);
            end
        join
        #23.7 rst = 1'b0;
        rd_cycles(10);
        b0 = rx0.size();
        sync_wr();
        wr_word(0, 8'hA5);
        wait_rx(0, b0 + 1, 100, "t5_count");
        rd_cycles(10);
        check("t5_alone", 32'(rx0.size() - b0), 32'd1);
        check("t5_word",  32'(rx0[b0]), 32'hA5);

        // 6: random traffic at two clock ratios against a scoreboard
        for (int ph = 0; ph < 2; ph++) begin
            wr_half = (ph == 0) ? 5.0 : 3.3;
            rd_half = (ph == 0) ? 3.1 : 9.7;
            exp0.delete();
            exp1.delete();
            b0 = rx0.size();
            b1 = rx1.size();
            wr_done = 1'b0;
            fork
                begin
                    repeat (600) begin
                        @(posedge wr_clk);
                        #1;
                        en0 = 1'($urandom_range(0, 1));
                        en1 = 1'($urandom_range(0, 1));
                        d0  = DW'($urandom);
                        d1  = DW'($urandom);
                        if (en0) begin
                            if (if0.wr_full) drops0++;
                            else             exp0.push_back(d0);
                        end
                        if (en1) begin
                            if (if1.wr_full) drops1++;
                            else             exp1.push_back(d1);
                        end
                        if0.wr_en = en0; if0.wr_dat = d0;
                        if1.wr_en = en1; if1.wr_dat = d1;
                    end
                    @(posedge wr_clk);
                    #1;
                    if0.wr_en = 1'b0;
                    if1.wr_en = 1'b0;
                    wr_done = 1'b1;
                end
                while (!wr_done) begin
                    @(posedge rd_clk);
                    #1;
                    if1.rd_rdy = ($urandom_range(0, 3) != 0);
                end
            join
            if1.rd_rdy = 1'b1;
            wait_rx(0, b0 + exp0.size(), 4000, $sformatf("t6_ph%0d_count0", ph));
            wait_rx(1, b1 + exp1.size(), 4000, $sformatf("t6_ph%0d_count1", ph));
            rd_cycles(10);
            check($sformatf("t6_ph%0d_exact0", ph), 32'(rx0.size() - b0), 32'(exp0.size()));
            check($sformatf("t6_ph%0d_exact1", ph), 32'(rx1.size() - b1), 32'(exp1.size()));
            for (int i = 0; i < exp0.size(); i++)
                check($sformatf("t6_ph%0d_w0_%0d", ph, i),
                      32'((b0 + i < rx0.size()) ? rx0[b0+i] : ~exp0[i]), 32'(exp0[i]));
            for (int i = 0; i < exp1.size(); i++)
                check($sformatf("t6_ph%0d_w1_%0d", ph, i),
                      32'((b1 + i < rx1.size()) ? rx1[b1+i] : ~exp1[i]), 32'(exp1[i]));
            if1.rd_rdy = 1'b0;
        end
        check("t6_ovf0", 32'(if0.wr_ovf), 32'(drops0 > 0));
        check("t6_ovf1", 32'(if1.wr_ovf), 32'(drops1 > 0));
`ifdef CDC_STREAM_FIFO_OVF_CNT_EN
        check("t6_ovf_cnt0", 32'(if0.ovf_cnt), 32'(drops0));
        check("t6_ovf_cnt1", 32'(if1.ovf_cnt), 32'(drops1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
